// File: rtl/namco_cctl_pkg.sv
// Shared definitions for the Namco CPU control block: register offsets,
// readback addresses and the period register type.
package namco_cctl_pkg;

    typedef logic [7:0] period_t;

    localparam logic [2:0] RD_PEND   = 3'd0;
    localparam logic [2:0] RD_IRQEN  = 3'd1;
    localparam logic [2:0] RD_PERIOD = 3'd2;
    localparam logic [2:0] RD_NMI    = 3'd3;

    function automatic logic [2:0] irq_en_addr(input int i);
        return 3'(i);
    endfunction

    function automatic logic [2:0] nmi_addr(input int ncpu);
        return 3'(ncpu);
    endfunction

    function automatic logic [2:0] rst_addr(input int ncpu);
        return 3'(ncpu + 1);
    endfunction

    function automatic logic [2:0] period_addr(input int ncpu);
        return 3'(ncpu + 2);
    endfunction

endpackage

// File: rtl/namco_cpu_ctrl_if.sv
// Main-CPU register bus seen by the control block: select, strobe, data.
interface namco_cpu_ctrl_if;
    logic [2:0] AD;
    logic       WR;
    logic [7:0] DI;
    logic [7:0] DO;

    modport master (output AD, output WR, output DI, input DO);
    modport slave  (input AD, input WR, input DI, output DO);
endinterface

// File: rtl/namco_cctl_timer.sv
// NMI timer: free-running prescaler, programmable period counter, wrap pulse
// and an NMI stretcher that holds NMI for NMI_WIDTH cycles after each wrap.
module namco_cctl_timer
    import namco_cctl_pkg::*;
#(
    parameter int PRE_DIV   = 16,
    parameter int NMI_WIDTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  period_t period,
    input  logic    period_wr,
    input  logic    clr,
    output logic    wrap,
    output logic    nmi
);
    localparam int PW = $clog2(PRE_DIV);
    localparam int SW = $clog2(NMI_WIDTH + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);
    localparam logic [SW-1:0] STRETCH  = SW'(NMI_WIDTH);

    logic [PW-1:0] presc_q, presc_d;
    period_t       cnt_q, cnt_d;
    logic [SW-1:0] str_q, str_d;
    logic          nmi_q, nmi_d;
    logic          tick_s, run_s, at_end_s;

    // Next-state: a period write or clear restarts the count and swallows a coincident wrap
    always_comb begin
        tick_s   = (presc_q == PRE_LAST);
        presc_d  = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        run_s    = tick_s & en & (period != 8'd0);
        at_end_s = (cnt_q == period - 8'd1);
        wrap     = run_s & at_end_s & ~period_wr & ~clr;
        if (period_wr | clr) begin
            cnt_d = 8'd0;
        end else if (run_s) begin
            cnt_d = at_end_s ? 8'd0 : cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (wrap) begin
            str_d = STRETCH;
        end else if (str_q != {SW{1'b0}}) begin
            str_d = str_q - SW'(1);
        end else begin
            str_d = str_q;
        end
        nmi_d = (str_d != {SW{1'b0}});
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= {PW{1'b0}};
            cnt_q   <= 8'd0;
            str_q   <= {SW{1'b0}};
            nmi_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            str_q   <= str_d;
            nmi_q   <= nmi_d;
        end
    end

    assign nmi = nmi_q;

endmodule

// File: rtl/namco_cpu_ctrl.sv
// CPU reset / IRQ / NMI latch for Namco multi-CPU boards, NCPU CPUs.
// Define NAMCO_CPU_CTRL_IACK_EN to let IACK pulses clear pending IRQs.
module namco_cpu_ctrl
    import namco_cctl_pkg::*;
#(
    parameter int NCPU       = 3,
    parameter int PRE_DIV    = 16,
    parameter int PERIOD_RST = 125,
    parameter int NMI_WIDTH  = 1
) (
    input  logic              CL,
    input  logic              RESET_N,
    namco_cpu_ctrl_if.slave   bus,
    input  logic              VBLK,
    input  logic [NCPU-1:0]   IACK,
    output logic [NCPU-1:0]   RSTS,
    output logic [NCPU-1:0]   IRQS,
    output logic              NMI
);
    localparam logic [2:0]      A_NMI     = nmi_addr(NCPU);
    localparam logic [2:0]      A_RST     = rst_addr(NCPU);
    localparam logic [2:0]      A_PER     = period_addr(NCPU);
    localparam logic [NCPU-1:0] CPU0_MASK = NCPU'(1);

    logic [NCPU-1:0] irqen_q, irqen_d, pend_q, pend_d, iack_s;
    logic            nmien_q, nmien_d, npend_q, npend_d;
    logic            sub_rst_q, sub_rst_d, vblk_q;
    period_t         period_q, period_d;
    logic            vblk_edge_s, nmi_wr_s, rst_wr_s, per_wr_s, nmi_clr_s, wrap_s;

`ifdef NAMCO_CPU_CTRL_IACK_EN
    assign iack_s = IACK;
`else
    logic unused_iack_s;
    assign iack_s        = {NCPU{1'b0}};
    assign unused_iack_s = ^IACK;
`endif

    assign vblk_edge_s = VBLK & ~vblk_q;
    assign nmi_wr_s    = bus.WR & (bus.AD == A_NMI);
    assign rst_wr_s    = bus.WR & (bus.AD == A_RST);
    assign per_wr_s    = bus.WR & (bus.AD == A_PER);
    assign nmi_clr_s   = nmi_wr_s & bus.DI[0];

    // Per-CPU enables and pending: a clearing write beats a VBLK edge, which beats IACK
    always_comb begin
        irqen_d = irqen_q;
        pend_d  = pend_q;
        for (int i = 0; i < NCPU; i++) begin
            if (vblk_edge_s & irqen_q[i]) begin
                pend_d[i] = 1'b1;
            end else if (iack_s[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
            if (bus.WR & (bus.AD == irq_en_addr(i))) begin
                irqen_d[i] = bus.DI[0];
                pend_d[i]  = pend_d[i] & bus.DI[0];
            end else begin
                irqen_d[i] = irqen_q[i];
            end
        end
    end

    // NMI control, sub-CPU reset latch and period register
    always_comb begin
        nmien_d   = nmi_wr_s ? ~bus.DI[0] : nmien_q;
        npend_d   = nmi_clr_s ? 1'b0 : (npend_q | wrap_s);
        sub_rst_d = rst_wr_s ? ~bus.DI[0] : sub_rst_q;
        period_d  = per_wr_s ? bus.DI : period_q;
    end

    // Control register bank
    always_ff @(posedge CL or negedge RESET_N) begin
        if (!RESET_N) begin
            irqen_q   <= {NCPU{1'b0}};
            pend_q    <= {NCPU{1'b0}};
            nmien_q   <= 1'b0;
            npend_q   <= 1'b0;
            sub_rst_q <= 1'b1;
            period_q  <= 8'(PERIOD_RST);
            vblk_q    <= 1'b0;
        end else begin
            irqen_q   <= irqen_d;
            pend_q    <= pend_d;
            nmien_q   <= nmien_d;
            npend_q   <= npend_d;
            sub_rst_q <= sub_rst_d;
            period_q  <= period_d;
            vblk_q    <= VBLK;
        end
    end

    namco_cctl_timer #(
        .PRE_DIV   (PRE_DIV),
        .NMI_WIDTH (NMI_WIDTH)
    ) u_timer (
        .clk       (CL),
        .rst_n     (RESET_N),
        .en        (nmien_q),
        .period    (period_q),
        .period_wr (per_wr_s),
        .clr       (nmi_clr_s),
        .wrap      (wrap_s),
        .nmi       (NMI)
    );

    // Status readback
    always_comb begin
        case (bus.AD)
            RD_PEND:   bus.DO = 8'(pend_q);
            RD_IRQEN:  bus.DO = 8'(irqen_q);
            RD_PERIOD: bus.DO = period_q;
            RD_NMI:    bus.DO = {6'b000000, nmien_q, npend_q};
            default:   bus.DO = 8'hFF;
        endcase
    end

    // Main CPU is never held; all CPUs are held while RESET_N is low
    assign RSTS = RESET_N ? ({NCPU{sub_rst_q}} & ~CPU0_MASK) : {NCPU{1'b1}};
    assign IRQS = pend_q & irqen_q;

endmodule

// File: tb/tb_namco_cpu_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model (NCPU=3), and a directed parameter check at NCPU=5.
module tb_namco_cpu_ctrl;
    import namco_cctl_pkg::*;

    localparam int P = 4;
    localparam int W = 2;
`ifdef NAMCO_CPU_CTRL_IACK_EN
    localparam bit IACK_ON = 1'b1;
`else
    localparam bit IACK_ON = 1'b0;
`endif

    logic CL = 1'b0;
    logic RESET_N;
    always #5 CL = ~CL;

    namco_cpu_ctrl_if bus3();
    namco_cpu_ctrl_if bus5();
    logic       vblk3, nmi3, vblk5, nmi5;
    logic [2:0] iack3, rsts3, irqs3;
    logic [4:0] iack5, rsts5, irqs5;

    namco_cpu_ctrl #(.NCPU(3), .PRE_DIV(P), .PERIOD_RST(125), .NMI_WIDTH(W)) u_dut3 (
        .CL(CL), .RESET_N(RESET_N), .bus(bus3), .VBLK(vblk3), .IACK(iack3),
        .RSTS(rsts3), .IRQS(irqs3), .NMI(nmi3));

    namco_cpu_ctrl #(.NCPU(5), .PRE_DIV(P), .PERIOD_RST(125), .NMI_WIDTH(1)) u_dut5 (
        .CL(CL), .RESET_N(RESET_N), .bus(bus5), .VBLK(vblk5), .IACK(iack5),
        .RSTS(rsts5), .IRQS(irqs5), .NMI(nmi5));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the NCPU=3 instance
    bit [2:0] m_pend, m_en;
    bit       m_nen, m_npend, m_sub, m_vprev;
    int       m_period, m_presc, m_cnt, m_left;

    task automatic model_reset();
        m_pend = 3'd0; m_en = 3'd0; m_nen = 1'b0; m_npend = 1'b0; m_sub = 1'b1;
        m_vprev = 1'b0; m_period = 125; m_presc = 0; m_cnt = 0; m_left = 0;
    endtask

    function automatic logic [7:0] model_do(input logic [2:0] ad);
        case (ad)
            3'd0:    return {5'd0, m_pend};
            3'd1:    return {5'd0, m_en};
            3'd2:    return 8'(m_period);
            3'd3:    return {6'd0, m_nen, m_npend};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_update(input logic wr, input logic [2:0] ad, input logic [7:0] di,
                                input logic vblk, input logic [2:0] iack);
        bit       edge_v = vblk && !m_vprev;
        bit       tick = (m_presc == P - 1);
        bit       wrap = 1'b0;
        bit [2:0] en_old = m_en;
        m_presc = (m_presc + 1) % P;
        if (tick && m_nen && m_period != 0) begin
            m_cnt++;
            if (m_cnt == m_period) begin m_cnt = 0; wrap = 1'b1; end
        end
        for (int i = 0; i < 3; i++) begin
            if (edge_v && en_old[i]) m_pend[i] = 1'b1;
            else if (IACK_ON && iack[i]) m_pend[i] = 1'b0;
        end
        if (wr) begin
            if (ad < 3'd3) begin
                m_en[ad] = di[0];
                if (!di[0]) m_pend[ad] = 1'b0;
            end else if (ad == 3'd3) begin
                m_nen = !di[0];
                if (di[0]) begin m_npend = 1'b0; m_cnt = 0; wrap = 1'b0; end
            end else if (ad == 3'd4) begin
                m_sub = !di[0];
            end else if (ad == 3'd5) begin
                m_period = di; m_cnt = 0; wrap = 1'b0;
            end
        end
        if (m_left > 0) m_left--;
        if (wrap) begin m_npend = 1'b1; m_left = W; end
        m_vprev = vblk;
    endtask

    // One CL cycle on the NCPU=3 instance, entered and left just after a falling edge
    task automatic step(input logic wr, input logic [2:0] ad, input logic [7:0] di,
                        input logic vblk, input logic [2:0] iack);
        check_val("irqs", irqs3, m_pend & m_en);
        check_val("nmi", nmi3, m_left > 0);
        check_val("rsts", rsts3, {m_sub, m_sub, 1'b0});
        bus3.WR = wr; bus3.AD = ad; bus3.DI = di; vblk3 = vblk; iack3 = iack;
        #1;
        check_val("do", bus3.DO, model_do(ad));
        model_update(wr, ad, di, vblk, iack);
        @(negedge CL);
    endtask

    task automatic step5(input logic wr, input logic [2:0] ad, input logic [7:0] di, input logic vblk);
        bus5.WR = wr; bus5.AD = ad; bus5.DI = di; vblk5 = vblk;
        @(negedge CL);
    endtask

    initial begin
        int  last, hi, rises, wait_n;
        bit  prev, found, rv;
        RESET_N = 1'b0;
        bus3.WR = 1'b0; bus3.AD = 3'd0; bus3.DI = 8'd0; vblk3 = 1'b0; iack3 = 3'd0;
        bus5.WR = 1'b0; bus5.AD = 3'd0; bus5.DI = 8'd0; vblk5 = 1'b0; iack5 = 5'd0;
        model_reset();
        repeat (2) @(posedge CL);
        @(negedge CL);
        check_val("rst_rsts", rsts3, 3'b111);
        check_val("rst_irqs", irqs3, 3'b000);
        check_val("rst_nmi", nmi3, 1'b0);
        RESET_N = 1'b1;
        #1;
        check_val("rel_rsts", rsts3, 3'b110);

        // VBLK IRQ, no retrigger while high, then acknowledge
        step(1'b1, 3'd0, 8'd1, 1'b0, 3'd0);
        step(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        check_val("vblk_irq", irqs3, 3'b001);
        repeat (8) step(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        check_val("vblk_level", irqs3, 3'b001);
        step(1'b0, 3'd0, 8'd0, 1'b1, 3'b001);
        check_val("iack", irqs3, IACK_ON ? 3'b000 : 3'b001);
        step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);

        // Timer NMI: period 3 ticks of 4 cycles
        step(1'b1, 3'd5, 8'd3, 1'b0, 3'd0);
        step(1'b1, 3'd3, 8'd0, 1'b0, 3'd0);
        prev = nmi3; last = -1; hi = 0; rises = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
            if (nmi3 && !prev) begin
                if (last >= 0) check_val("nmi_period", 8'(k - last), 8'd12);
                last = k; rises++;
            end
            if (nmi3) hi++;
            else if (prev) begin check_val("nmi_width", 8'(hi), 8'(W)); hi = 0; end
            prev = nmi3;
        end
        check_val("nmi_rises", 8'(rises >= 4), 8'd1);
        step(1'b1, 3'd3, 8'd1, 1'b0, 3'd0);
        prev = nmi3; rises = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 3'd3, 8'd0, 1'b0, 3'd0);
            if (nmi3 && !prev) rises++;
            prev = nmi3;
        end
        check_val("nmi_off", 8'(rises), 8'd0);
        check_val("nmi_off_rd", bus3.DO, 8'd0);

        // Collisions
        step(1'b1, 3'd0, 8'd1, 1'b0, 3'd0);
        step(1'b1, 3'd0, 8'd0, 1'b1, 3'd0);
        check_val("clr_beats_edge", bus3.DO[0], 1'b0);
        step(1'b1, 3'd0, 8'd1, 1'b0, 3'd0);
        step(1'b0, 3'd0, 8'd0, 1'b1, 3'b001);
        check_val("edge_beats_iack", bus3.DO[0], 1'b1);
        step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
        step(1'b1, 3'd3, 8'd0, 1'b0, 3'd0);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_presc == P - 1 && m_nen && m_period != 0 && m_cnt == m_period - 1) begin
                found = 1'b1; break;
            end
            step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
        end
        check_val("wrap_found", found, 1'b1);
        step(1'b1, 3'd5, 8'd3, 1'b0, 3'd0);
        wait_n = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
            if (nmi3) begin wait_n = k; break; end
        end
        check_val("period_wr_wrap", 8'(wait_n), 8'd12);

        // Sub-CPU reset latch
        step(1'b1, 3'd4, 8'd1, 1'b0, 3'd0);
        check_val("sub_rel", rsts3, 3'b000);
        step(1'b1, 3'd4, 8'd0, 1'b0, 3'd0);
        check_val("sub_hold", rsts3, 3'b110);

        // Asynchronous reset in the middle of a timer run
        step(1'b1, 3'd3, 8'd0, 1'b0, 3'd0);
        step(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        repeat (6) step(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        vblk3 = 1'b0;
        RESET_N = 1'b0;
        #1;
        check_val("mid_rst_irqs", irqs3, 3'b000);
        check_val("mid_rst_nmi", nmi3, 1'b0);
        check_val("mid_rst_rsts", rsts3, 3'b111);
        model_reset();
        @(negedge CL);
        RESET_N = 1'b1;
        #1;
        check_val("mid_rel_rsts", rsts3, 3'b110);
        bus3.AD = 3'd2;
        #1;
        check_val("mid_rel_period", bus3.DO, 8'd125);

        // Random traffic
        rv = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            logic       wr;
            logic [2:0] ad;
            logic [7:0] di;
            wr = ($urandom_range(0, 3) == 0);
            ad = 3'($urandom_range(0, 7));
            di = (ad == 3'd5) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            if ($urandom_range(0, 3) == 0) rv = ~rv;
            step(wr, ad, di, rv, ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0);
        end
        step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);

        // NCPU=5 address map
        check_val("rst5", rsts5, 5'b11110);
        step5(1'b1, 3'd0, 8'd1, 1'b0);
        step5(1'b1, 3'd2, 8'd1, 1'b0);
        step5(1'b1, 3'd4, 8'd1, 1'b0);
        step5(1'b0, 3'd0, 8'd0, 1'b1);
        check_val("irq5", irqs5, 5'b10101);
        check_val("pend5", bus5.DO, 8'h15);
        step5(1'b0, 3'd1, 8'd0, 1'b1);
        check_val("irqs5_hold", irqs5, 5'b10101);
        check_val("irqen5", bus5.DO, 8'h15);
        step5(1'b1, 3'd6, 8'd1, 1'b1);
        check_val("rst5_rel", rsts5, 5'b00000);
        step5(1'b1, 3'd7, 8'd2, 1'b1);
        step5(1'b0, 3'd2, 8'd0, 1'b1);
        check_val("per5", bus5.DO, 8'd2);
        step5(1'b1, 3'd5, 8'd0, 1'b1);
        prev = nmi5; last = -1; hi = 0; rises = 0;
        for (int k = 0; k < 40; k++) begin
            step5(1'b0, 3'd0, 8'd0, 1'b1);
            if (nmi5 && !prev) begin
                if (last >= 0) check_val("nmi5_period", 8'(k - last), 8'd8);
                last = k; rises++;
            end
            if (nmi5) hi++;
            else if (prev) begin check_val("nmi5_width", 8'(hi), 8'd1); hi = 0; end
            prev = nmi5;
        end
        check_val("nmi5_rises", 8'(rises >= 3), 8'd1);
        step5(1'b1, 3'd5, 8'd1, 1'b1);
        step5(1'b1, 3'd6, 8'd0, 1'b1);
        check_val("rst5_hold", rsts5, 5'b11110);
        step5(1'b0, 3'd3, 8'd0, 1'b1);
        check_val("nmi5_rd", bus5.DO, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/namco_cpu_ctrl.md
Name: namco_cpu_ctrl

Overview:
- Parametrised CPU control and interrupt latch block for Namco-style multi-CPU boards.
- Generalises the fixed three-CPU latch to NCPU CPUs.
- Adds edge-triggered VBLANK IRQs, an NMI timer whose period the CPU can program, per-CPU IRQ acknowledge, and a status readback port.
- Sits on the main-CPU bus beside the video latches; drives CPU reset, IRQ and NMI lines.

Parameters:
- NCPU, 3, number of CPUs served; legal range 1..5. CPU0 is the main CPU, CPU NCPU-1 receives the timer NMI.
- PRE_DIV, 16, CL cycles per timer tick; must be at least 2.
- PERIOD_RST, 125, reset value of the period register, in ticks. 0 stops the timer.
- NMI_WIDTH, 1, NMI pulse stretch in CL cycles after pending is set; must be at least 1.

Ports:
- CL  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- AD  in  3  register select, decoded by the parent to a 8-byte window.
- WR  in  1  write strobe, one CL cycle per write.
- DI  in  8  write data.
- DO  out  8  readback data, combinational from AD.
- VBLK  in  1  vertical blank level, synchronous to CL.
- IACK  in  NCPU  per-CPU IRQ acknowledge pulse.
- RSTS  out  NCPU  per-CPU reset, active-high.
- IRQS  out  NCPU  per-CPU IRQ, active-high level.
- NMI  out  1  timer NMI to CPU NCPU-1, active-high.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - IRQ enables and IRQ pending bits are 0.
  - NMI enable and NMI pending are 0.
  - Sub-CPU reset latch is 1.
  - Period register is PERIOD_RST; prescaler and period counters are 0.
  - VBLK history register is 0.
- Outputs during and after reset:
  - IRQS=0 and NMI=0.
  - RSTS = all ones during reset.
  - After reset, RSTS[0]=0 and RSTS[NCPU-1:1] = the sub-CPU reset latch.
- Write map (WR=1, decided at the CL edge):
  - AD=i, for i<NCPU: IRQEN[i] <= DI[0]. If DI[0]=0, PEND[i] <= 0.
  - AD=NCPU: NMIEN <= ~DI[0]. If DI[0]=1, NMI pending <= 0 and the period counter is cleared.
  - AD=NCPU+1: sub-CPU reset latch <= ~DI[0]. Takes effect on RSTS the next cycle.
  - AD=NCPU+2: PERIOD <= DI. The period counter restarts from 0.
  - Any other address is ignored.
- IRQ behaviour:
  - A rising edge on VBLK (VBLK=1 while the registered VBLK was 0) sets PEND[i] for every i where IRQEN[i]=1.
  - IRQS[i] = PEND[i] & IRQEN[i]. Latency is one CL cycle from the VBLK edge to IRQS.
  - A level-high VBLK does not set pending again.
- Timer:
  - The prescaler counts 0..PRE_DIV-1 continuously; the wrap is the tick.
  - On each tick, if NMIEN=1 and PERIOD!=0, the period counter increments.
  - When the period counter reaches PERIOD-1 on a tick, it wraps to 0 and NMI pending is set.
  - NMI is high for exactly NMI_WIDTH cycles starting the cycle after pending is set. It then stays low until the next set.
  - NMI pending is a status bit only; it does not hold NMI high.
  - PERIOD=0 freezes the period counter; the prescaler keeps running.
- Simultaneous events:
  - A write that clears a pending bit beats a set from a VBLK edge or timer wrap in the same cycle.
  - A VBLK edge beats IACK in the same cycle: pending stays set.
  - A PERIOD write in the same cycle as a wrap: the new period loads, the counter goes to 0, and no NMI is raised.
- Readback:
  - AD=0: DO = {zero pad, PEND[NCPU-1:0]}.
  - AD=1: DO = {zero pad, IRQEN}.
  - AD=2: DO = PERIOD.
  - AD=3: DO = {6'b0, NMIEN, NMI pending}.
  - Other addresses read 8'hFF.

Optional Feature:
- Macro: NAMCO_CPU_CTRL_IACK_EN.
- With the macro defined: IACK[i]=1 clears PEND[i] on that edge, subject to the simultaneous-event rule above.
- Without the macro: the IACK port still exists but is ignored. Pending bits clear only when the CPU writes 0 to the enable register.

Decomposition:
- Shared package namco_cctl_pkg holds:
  - register offset functions of NCPU (irq_en_addr(i), nmi_addr, rst_addr, period_addr);
  - the readback address constants 0..3;
  - the 8-bit period type.
- One sub-module, namco_cctl_timer. It contains the prescaler, period counter, wrap pulse and NMI_WIDTH stretcher. It takes the enable, period, period-write and clear inputs, and outputs the wrap pulse and NMI.

Test Plan:
- Reset check: pulse RESET_N low mid-timer, with NMIEN=1 and counters nonzero -> the same cycle shows IRQS=0, NMI=0, RSTS=3'b111. After release: RSTS=3'b110, readback AD=2 returns 125.
- VBLK IRQ with acknowledge: write AD=0 DI=1, then raise VBLK for 10 cycles.
  - Expect IRQS=3'b001 one cycle after the edge, with no retrigger while VBLK stays high.
  - IACK[0] pulse -> IRQS=0 (macro on), or IRQS stays 1 (macro off).
- Timer NMI: PRE_DIV=4, write AD=5 DI=3, then write AD=3 DI=0.
  - Expect NMI pulses every 12 cycles, each NMI_WIDTH wide.
  - Then write AD=3 DI=1 -> no further NMI pulses, and AD=3 reads 0.
- Collision cases:
  - Write AD=0 DI=0 on the same cycle as a VBLK edge -> PEND[0]=0.
  - VBLK edge plus IACK[0] on the same cycle -> PEND[0]=1.
  - PERIOD write on a wrap cycle -> no NMI; the next NMI comes a full new period later.
- Sub-CPU reset: write AD=4 DI=1 -> RSTS=3'b000 the next cycle. Then write AD=4 DI=0 -> RSTS=3'b110.
- Parameter sweep with NCPU=5: IRQEN addresses 0..4, NMI at 5, reset at 6, period at 7. Repeat the VBLK and timer scenarios with IRQS=5'b10101 expected after enabling CPUs 0, 2 and 4.
